hilo_div_ctrl: RTL and testbench

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

---
 rtl/hilo_div_ctrl.sv | 158 +++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// HI/LO divide controller: multi-cycle restoring divider for DIV/DIVU.
// Stalls the pipeline while running and writes HI/LO with a one-cycle pulse.
module hilo_div_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        o_we,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        ZERO,
        RUN,
        DONE
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(DIV_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [64:0] work;
    logic [31:0] dvs;
    logic        q_neg;
    logic        r_neg;
    logic        zero_div;

    logic        accept;
    logic        dd_neg;
    logic        dv_neg;
    logic [31:0] dd_abs;
    logic [31:0] dv_abs;
    logic [64:0] shifted;
    logic [33:0] diff;
    logic [64:0] step;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_out;
    logic [31:0] rem_out;

    assign accept = start && !flush;

    // Operand magnitudes and one restoring shift-subtract step
    always_comb begin
        dd_neg  = signed_op && dividend[31];
        dv_neg  = signed_op && divisor[31];
        dd_abs  = dd_neg ? (32'd0 - dividend) : dividend;
        dv_abs  = dv_neg ? (32'd0 - divisor) : divisor;
        shifted = work << 1;
        diff    = {1'b0, shifted[64:32]} - {2'b00, dvs};
        step    = shifted;
        if (!diff[33]) begin
            step = {diff[32:0], shifted[31:0] | 32'd1};
        end
        quo     = work[31:0];
        rem     = work[63:32];
        quo_out = q_neg ? (32'd0 - quo) : quo;
        rem_out = r_neg ? (32'd0 - rem) : rem;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, iteration counter and working register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 5'd0;
            work     <= 65'd0;
            dvs      <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_div <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= 5'd0;
                        work     <= {33'd0, dd_abs};
                        dvs      <= dv_abs;
                        q_neg    <= dd_neg ^ dv_neg;
                        r_neg    <= dd_neg;
                        zero_div <= (divisor == 32'd0);
                    end
                end
                RUN: begin
                    if (!flush) begin
                        work <= step;
                        cnt  <= cnt + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        busy        = 1'b0;
        o_we        = 1'b0;
        o_hi        = 32'd0;
        o_lo        = 32'd0;
        div_by_zero = 1'b0;
        unique case (state)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    state_nxt = (divisor == 32'd0) ? ZERO : RUN;
                end
            end
            ZERO: begin
                stall     = 1'b1;
                busy      = 1'b1;
                state_nxt = flush ? IDLE : DONE;
            end
            RUN: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                o_we        = !flush;
                div_by_zero = zero_div;
                o_hi        = zero_div ? 32'd0 : rem_out;
                o_lo        = zero_div ? 32'd0 : quo_out;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Testbench for hilo_div_ctrl: table vectors, directed corner sequences
// and randomized operands against an arithmetic reference model.
module tb_hilo_div_ctrl;

    // 32 RUN cycles, then the DONE cycle carrying the write pulse
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        o_we;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    hilo_div_ctrl #(.DIV_CYCLES(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .o_we       (o_we),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } vec_t;

    vec_t tbl [12];

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: divide magnitudes, then apply the DIV sign rules
    function automatic void ref_div(input logic sop, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] lo,
                                    output logic [31:0] hi,
                                    output logic dbz);
        logic [31:0] ua, ub, q, r;
        logic na, nb;
        if (b == 32'd0) begin
            lo = 32'd0;
            hi = 32'd0;
            dbz = 1'b1;
            return;
        end
        na = sop && a[31];
        nb = sop && b[31];
        ua = na ? -a : a;
        ub = nb ? -b : b;
        q = ua / ub;
        r = ua % ub;
        lo = (na ^ nb) ? -q : q;
        hi = na ? -r : r;
        dbz = 1'b0;
    endfunction

    task automatic all_zero(input string nm);
        chk1({nm, ".stall"}, stall, 1'b0);
        chk1({nm, ".busy"}, busy, 1'b0);
        chk1({nm, ".o_we"}, o_we, 1'b0);
        chk1({nm, ".dbz"}, div_by_zero, 1'b0);
        chk32({nm, ".o_hi"}, o_hi, 32'd0);
        chk32({nm, ".o_lo"}, o_lo, 32'd0);
    endtask

    task automatic no_we(input string nm, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (o_we) seen++;
        end
        chk_int({nm, ".no_we"}, seen, 0);
    endtask

    // One full operation, start held while stall is high
    task automatic do_div(input string nm, input logic sop,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input logic edbz);
        int lat, pulses, exp_lat;
        logic [31:0] glo, ghi;
        logic gdbz, stall_ok, fin;
        exp_lat = (b == 32'd0) ? 2 : DIV_LAT;
        lat = 0;
        pulses = 0;
        glo = 32'd0;
        ghi = 32'd0;
        gdbz = 1'b0;
        stall_ok = 1'b1;
        fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        signed_op = sop;
        dividend = a;
        divisor = b;
        flush = 1'b0;
        #1 chk1({nm, ".req_stall"}, stall, 1'b1);
        for (int k = 1; k <= 45 && !fin; k++) begin
            @(negedge clk);
            if (o_we) begin
                pulses++;
                if (pulses == 1) begin
                    lat = k;
                    glo = o_lo;
                    ghi = o_hi;
                    gdbz = div_by_zero;
                end
                if (stall) stall_ok = 1'b0;
            end else if (busy && !stall) begin
                stall_ok = 1'b0;
            end
            if (!busy && pulses > 0) fin = 1'b1;
            if (!stall) start = 1'b0;
        end
        start = 1'b0;
        chk_int({nm, ".pulses"}, pulses, 1);
        chk_int({nm, ".latency"}, lat, exp_lat);
        chk32({nm, ".o_lo"}, glo, elo);
        chk32({nm, ".o_hi"}, ghi, ehi);
        chk1({nm, ".dbz"}, gdbz, edbz);
        chk1({nm, ".stall_shape"}, stall_ok, 1'b1);
    endtask

    initial begin
        logic [31:0] ra, rb, elo, ehi;
        logic rs, edbz;
        int pulses, p1, p2, sel;
        logic [31:0] lo2, hi2;

        tbl[0]  = '{1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0};
        tbl[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        tbl[2]  = '{1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0};
        tbl[3]  = '{1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'h00000001, 1'b0};
        tbl[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 32'd5, 32'd0, 32'h0, 32'h0, 1'b1};
        tbl[6]  = '{1'b1, 32'hFFFFFFFB, 32'd0, 32'h0, 32'h0, 1'b1};
        tbl[7]  = '{1'b0, 32'd0, 32'd5, 32'h0, 32'h0, 1'b0};
        tbl[8]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0};
        tbl[9]  = '{1'b0, 32'd3, 32'hFFFFFFFF, 32'h0, 32'h3, 1'b0};
        tbl[10] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{1'b0, 32'h80000000, 32'h80000000, 32'h1, 32'h0, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        signed_op = 1'b0;
        dividend = 32'd0;
        divisor = 32'd0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        all_zero("idle");

        for (int i = 0; i < 12; i++) begin
            do_div($sformatf("vec%0d", i), tbl[i].sop, tbl[i].a, tbl[i].b,
                   tbl[i].lo, tbl[i].hi, tbl[i].dbz);
        end

        // Start with flush in IDLE: no stall, no capture
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        dividend = 32'd9;
        divisor = 32'd3;
        #1 chk1("idle_flush.stall", stall, 1'b0);
        @(negedge clk);
        chk1("idle_flush.busy", busy, 1'b0);
        start = 1'b0;
        flush = 1'b0;

        // Flush at RUN count 10, then an immediate DIVU 9/3
        @(negedge clk);
        start = 1'b1;
        signed_op = 1'b0;
        dividend = 32'd1000;
        divisor = 32'd3;
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (o_we) pulses++;
        end
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk1("run_flush.stall", stall, 1'b0);
        chk1("run_flush.busy", busy, 1'b0);
        chk_int("run_flush.early_we", pulses, 0);
        no_we("run_flush", 40);
        do_div("after_flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Flush in ZERO aborts the zero-divisor result
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd5;
        divisor = 32'd0;
        @(negedge clk);
        chk1("zero_flush.busy_in_zero", busy, 1'b1);
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk1("zero_flush.busy", busy, 1'b0);
        no_we("zero_flush", 5);

        // Flush in DONE gates the write pulse
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
        p1 = 0;
        for (int k = 1; k <= 40 && p1 == 0; k++) begin
            @(negedge clk);
            if (o_we) p1 = k;
        end
        chk_int("done_flush.reach_done", p1, DIV_LAT);
        flush = 1'b1;
        start = 1'b0;
        #1;
        chk1("done_flush.o_we", o_we, 1'b0);
        chk1("done_flush.stall", stall, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        chk1("done_flush.busy", busy, 1'b0);

        // Reset at RUN count 20
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd12345;
        divisor = 32'd11;
        for (int k = 1; k <= 21; k++) @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        all_zero("run_reset");
        no_we("run_reset", 40);

        // start held through DONE: next op accepted in the first IDLE cycle
        @(negedge clk);
        start = 1'b1;
        signed_op = 1'b0;
        dividend = 32'd20;
        divisor = 32'd3;
        pulses = 0;
        p1 = 0;
        p2 = 0;
        lo2 = 32'd0;
        hi2 = 32'd0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (o_we) begin
                pulses++;
                if (pulses == 1) p1 = k;
                if (pulses == 2) begin
                    p2 = k;
                    lo2 = o_lo;
                    hi2 = o_hi;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk_int("b2b.pulses", pulses, 2);
        chk_int("b2b.first", p1, DIV_LAT);
        chk_int("b2b.second", p2, 2 * DIV_LAT + 1);
        chk32("b2b.o_lo", lo2, 32'd6);
        chk32("b2b.o_hi", hi2, 32'd2);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                3: rb = 32'h80000000;
                4: begin
                    ra = 32'h80000000;
                    rb = $urandom;
                end
                default: rb = $urandom;
            endcase
            ref_div(rs, ra, rb, elo, ehi, edbz);
            do_div($sformatf("rnd%0d", i), rs, ra, rb, elo, ehi, edbz);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
